core_avl_arbiter: RTL and testbench
===================================

// Module: core_avl_arbiter
// PURPOSE
//  Two-master to one-slave Avalon-MM arbiter that sits directly downstream of the core.
//  It merges the instruction master (m0, from core_if) and the data master (m1, from core_ma) onto a single slave port.
//  Read responses are returned in order and routed back by a tracking FIFO of master IDs.
//  Requestors are served round-robin, one grant per accepted transfer.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_W       32  data width; byteenable width is DATA_W/8
//  MAX_PENDING  4   max outstanding reads (tracking FIFO depth, power of 2, >=2)
// PORTS
//  clk                          in   1         clock
//  rest                         in   1         synchronous active-high reset
//  m0_address / m1_address      in   ADDR_W    master address
//  m0_read / m1_read            in   1         read request
//  m0_write / m1_write          in   1         write request (m0 may tie 0)
//  m0_writedata / m1_writedata  in   DATA_W    write data
//  m0_byteenable / m1_byteenable in  DATA_W/8  byte enables
//  m0_waitrequest / m1_waitrequest out 1       stall to master
//  m0_readdata / m1_readdata    out  DATA_W    = s_readdata (broadcast)
//  m0_readdatavalid / m1_readdatavalid out 1   response strobe for that master
//  s_address                    out  ADDR_W    slave address
//  s_read / s_write             out  1         slave command
//  s_writedata / s_byteenable   out  DATA_W, DATA_W/8  slave write data / byte enables
//  s_waitrequest                in   1         slave stall
//  s_readdata                   in   DATA_W    slave read data
//  s_readdatavalid              in   1         slave read response
//  pending_cnt                  out  $clog2(MAX_PENDING)+1  outstanding reads
//  err_unexp_rdv                out  1         sticky: s_readdatavalid seen with FIFO empty
// BEHAVIOUR
//  - reqN = mN_read|mN_write. read&write together on one master is illegal; read wins.
//  - Grant is combinational, evaluated each cycle:
//    - only one req: that master is granted.
//    - both req: the master != last_gnt is granted.
//  - last_gnt resets to m0, so m1 (data) wins the first contention.
//    It updates only on an accepted transfer.
//  - Granted master's command drives s_*. With no req: s_read = s_write = 0; s_address/data don't-care.
//  - read_block = granted read && FIFO full. When set, s_read = 0.
//    No full-bypass: a pop in the same cycle does not unblock.
//  - Granted master's mN_waitrequest = s_waitrequest | read_block.
//  - Non-granted master's mN_waitrequest = 1. A master that is not requesting sees mN_waitrequest = 1.
//  - Accept = (s_read|s_write) && !s_waitrequest.
//    - On an accepted read, push the granted ID into the FIFO.
//    - Writes have no response and are never blocked by a full FIFO.
//  - On s_readdatavalid, pop the FIFO head and assert the matching mN_readdatavalid the same cycle (0-cycle response path).
//  - Simultaneous push and pop: count unchanged; data ordering preserved.
//  - Pointers wrap modulo MAX_PENDING. pending_cnt ranges 0..MAX_PENDING.
//  - s_readdatavalid with FIFO empty:
//    - no mN_readdatavalid is asserted;
//    - err_unexp_rdv is set and holds until reset.
//  - Command latency 0 cycles (combinational pass-through). Response latency 0 cycles added.
//  - Reset (including mid-transfer): FIFO emptied, pending_cnt = 0, err_unexp_rdv = 0, last_gnt = m0.
//    While rest = 1: s_read = s_write = 0, both mN_waitrequest = 1, both mN_readdatavalid = 0.
//    In-flight slave responses after reset are treated as unexpected.
// TESTING
//  1. m0 alone reads 0x100, slave rdv after 2 cycles with 0xDEADBEEF
//     -> m0_readdatavalid = 1 with 0xDEADBEEF, m1_readdatavalid = 0, pending_cnt 1 -> 0.
//  2. m0 and m1 both read continuously, s_waitrequest = 0
//     -> grants alternate m1, m0, m1, m0; responses routed to matching master in order.
//  3. m1 issues 4 reads with slave not responding, m1 then issues a 5th read
//     -> s_read = 0, m1_waitrequest = 1, pending_cnt = 4.
//     Next cycle a single rdv arrives -> 5th read accepted one cycle after the pop.
//  4. FIFO full, m1 issues a write to 0x200 data 0x12345678 be = 4'hF
//     -> s_write = 1 accepted, pending_cnt stays 4.
//  5. s_waitrequest held high for 3 cycles during a contended m0/m1 read
//     -> s_* stable, grant unchanged, last_gnt unchanged until accept.
//  6. rest pulsed with 2 reads outstanding, then 2 rdv arrive
//     -> no mN_readdatavalid asserted, err_unexp_rdv = 1, pending_cnt = 0.

Source files
------------

// File: rtl/core_avl_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter with round-robin grant.
// Read responses are routed back in order through a FIFO of master IDs.
module core_avl_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 4
) (
    input  logic                             clk,
    input  logic                             rest,
    input  logic [ADDR_W-1:0]                m0_address,
    input  logic                             m0_read,
    input  logic                             m0_write,
    input  logic [DATA_W-1:0]                m0_writedata,
    input  logic [DATA_W/8-1:0]              m0_byteenable,
    output logic                             m0_waitrequest,
    output logic [DATA_W-1:0]                m0_readdata,
    output logic                             m0_readdatavalid,
    input  logic [ADDR_W-1:0]                m1_address,
    input  logic                             m1_read,
    input  logic                             m1_write,
    input  logic [DATA_W-1:0]                m1_writedata,
    input  logic [DATA_W/8-1:0]              m1_byteenable,
    output logic                             m1_waitrequest,
    output logic [DATA_W-1:0]                m1_readdata,
    output logic                             m1_readdatavalid,
    output logic [ADDR_W-1:0]                s_address,
    output logic                             s_read,
    output logic                             s_write,
    output logic [DATA_W-1:0]                s_writedata,
    output logic [DATA_W/8-1:0]              s_byteenable,
    input  logic                             s_waitrequest,
    input  logic [DATA_W-1:0]                s_readdata,
    input  logic                             s_readdatavalid,
    output logic [$clog2(MAX_PENDING):0]     pending_cnt,
    output logic                             err_unexp_rdv
);

    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;

    logic                   last_gnt_q;
    logic [MAX_PENDING-1:0] id_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   err_q;

    logic req0, req1, gnt0, gnt1;
    logic g_read, g_write, full, empty, read_block;
    logic accept, push, pop, head;

    // Grant, command mux, stall and response routing
    always_comb begin
        req0       = m0_read | m0_write;
        req1       = m1_read | m1_write;
        gnt1       = req1 & (~req0 | ~last_gnt_q);
        gnt0       = req0 & ~gnt1;
        g_read     = (gnt0 & m0_read) | (gnt1 & m1_read);
        g_write    = (gnt0 & m0_write & ~m0_read)
                   | (gnt1 & m1_write & ~m1_read);
        full       = (cnt_q == CNT_W'(MAX_PENDING));
        empty      = (cnt_q == '0);
        read_block = g_read & full;
        s_read     = ~rest & g_read & ~read_block;
        s_write    = ~rest & g_write;
        s_address    = gnt1 ? m1_address    : m0_address;
        s_writedata  = gnt1 ? m1_writedata  : m0_writedata;
        s_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
        m0_waitrequest = rest | ~gnt0 | s_waitrequest | read_block;
        m1_waitrequest = rest | ~gnt1 | s_waitrequest | read_block;
        accept     = (s_read | s_write) & ~s_waitrequest;
        push       = accept & s_read;
        pop        = ~rest & s_readdatavalid & ~empty;
        head       = id_q[rd_ptr_q];
        m0_readdatavalid = pop & ~head;
        m1_readdatavalid = pop & head;
        m0_readdata  = s_readdata;
        m1_readdata  = s_readdata;
        pending_cnt  = cnt_q;
        err_unexp_rdv = err_q;
    end

    // Tracking FIFO, round-robin history and sticky error flag
    always_ff @(posedge clk) begin
        if (rest) begin
            last_gnt_q <= 1'b0;
            id_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (push) begin
                id_q[wr_ptr_q] <= gnt1;
                wr_ptr_q       <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (accept) begin
                last_gnt_q <= gnt1;
            end
            if (s_readdatavalid && empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_avl_arbiter.sv
// Randomised and directed bench for core_avl_arbiter.
// A queue-based reference model is compared against the DUT every cycle.
module tb_core_avl_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MP = 4;

    logic          clk = 1'b0;
    logic          rest;
    logic [AW-1:0] m0_address, m1_address, s_address;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [3:0]    m0_byteenable, m1_byteenable, s_byteenable;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic          s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [2:0]    pending_cnt;
    logic          err_unexp_rdv;

    always #5 clk = ~clk;

    core_avl_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MP)) dut (
        .clk(clk), .rest(rest),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .pending_cnt(pending_cnt), .err_unexp_rdv(err_unexp_rdv)
    );

    int errs = 0;
    int checks = 0;
    int nprint = 0;

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            if (nprint < 40)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
            nprint++;
        end
    endtask

    // Reference model: queue of master IDs awaiting a response
    int q[$];
    int last_g = 0;
    bit merr = 0;
    int eg = -1;
    bit e_rd = 0, e_wr = 0, e_acc = 0;
    bit r0, r1, grd, gwr, blk, epop;
    int hd;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    logic [3:0] gb;

    always @(negedge clk) begin
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (r0 && r1) eg = (last_g == 0) ? 1 : 0;
        else if (r0) eg = 0;
        else if (r1) eg = 1;
        else eg = -1;
        grd = (eg == 0) ? m0_read : (eg == 1) ? m1_read : 1'b0;
        gwr = (eg == 0) ? m0_write : (eg == 1) ? m1_write : 1'b0;
        ga = (eg == 1) ? m1_address : m0_address;
        gd = (eg == 1) ? m1_writedata : m0_writedata;
        gb = (eg == 1) ? m1_byteenable : m0_byteenable;
        blk = grd && (q.size() == MP);
        e_rd = !rest && grd && !blk;
        e_wr = !rest && !grd && gwr;
        e_acc = (e_rd || e_wr) && !s_waitrequest;
        hd = (q.size() > 0) ? q[0] : -1;
        epop = !rest && s_readdatavalid && (q.size() > 0);
        chk("s_read", s_read, e_rd);
        chk("s_write", s_write, e_wr);
        chk("m0_wait", m0_waitrequest, rest || eg != 0 || s_waitrequest || blk);
        chk("m1_wait", m1_waitrequest, rest || eg != 1 || s_waitrequest || blk);
        chk("m0_rdv", m0_readdatavalid, epop && hd == 0);
        chk("m1_rdv", m1_readdatavalid, epop && hd == 1);
        chk("pending", pending_cnt, q.size());
        chk("err", err_unexp_rdv, merr);
        chk("m0_rdata", m0_readdata, s_readdata);
        chk("m1_rdata", m1_readdata, s_readdata);
        if (e_rd || e_wr) chk("s_addr", s_address, ga);
        if (e_wr) begin
            chk("s_wdata", s_writedata, gd);
            chk("s_be", s_byteenable, gb);
        end
    end

    always @(posedge clk) begin
        if (rest) begin
            q.delete();
            last_g = 0;
            merr = 0;
        end else begin
            if (s_readdatavalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else merr = 1;
            end
            if (e_acc) begin
                if (e_rd) q.push_back(eg);
                last_g = eg;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int g;
    int exp2[4];

    initial begin
        exp2[0] = 1; exp2[1] = 0; exp2[2] = 1; exp2[3] = 0;
        rest = 1'b1;
        m0_address = '0; m0_read = 1'b1; m0_write = 1'b0;
        m0_writedata = '0; m0_byteenable = 4'hF;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0;
        m1_writedata = '0; m1_byteenable = 4'hF;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_sread", s_read, 0);
        chk("rst_m0wait", m0_waitrequest, 1);
        chk("rst_m1wait", m1_waitrequest, 1);
        chk("rst_pend", pending_cnt, 0);
        chk("rst_err", err_unexp_rdv, 0);

        // single read from m0
        tick(); rest = 1'b0; m0_address = 32'h100;
        @(negedge clk);
        chk("t1_sread", s_read, 1);
        chk("t1_addr", s_address, 32'h100);
        chk("t1_wait", m0_waitrequest, 0);
        tick(); m0_read = 1'b0;
        @(negedge clk); chk("t1_pend1", pending_cnt, 1);
        tick(); s_readdatavalid = 1'b1; s_readdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_rdv", m0_readdatavalid, 1);
        chk("t1_data", m0_readdata, 32'hDEADBEEF);
        chk("t1_m1rdv", m1_readdatavalid, 0);
        tick(); s_readdatavalid = 1'b0;
        @(negedge clk); chk("t1_pend0", pending_cnt, 0);

        // contention alternates m1, m0, m1, m0
        tick(); m0_read = 1'b1; m1_read = 1'b1;
        m0_address = 32'h1000; m1_address = 32'h2000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            g = !m1_waitrequest ? 1 : (!m0_waitrequest ? 0 : -1);
            chk("t2_gnt", g, exp2[i]);
            tick();
        end
        m0_read = 1'b0; m1_read = 1'b0;
        @(negedge clk); chk("t2_pend", pending_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            tick(); s_readdatavalid = 1'b1; s_readdata = i;
            @(negedge clk);
            chk("t2_route1", m1_readdatavalid, exp2[i]);
            chk("t2_route0", m0_readdatavalid, 1 - exp2[i]);
        end
        tick(); s_readdatavalid = 1'b0;

        // fill FIFO from m1, fifth read blocked, no full bypass
        m1_read = 1'b1; m1_address = 32'h300;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("t3_acc", m1_waitrequest, 0);
            tick();
        end
        @(negedge clk);
        chk("t3_blk_sread", s_read, 0);
        chk("t3_blk_wait", m1_waitrequest, 1);
        chk("t3_full", pending_cnt, 4);
        tick(); s_readdatavalid = 1'b1;
        @(negedge clk);
        chk("t3_nobypass", s_read, 0);
        chk("t3_pop", m1_readdatavalid, 1);
        tick(); s_readdatavalid = 1'b0;
        @(negedge clk);
        chk("t3_sread", s_read, 1);
        chk("t3_wait", m1_waitrequest, 0);
        chk("t3_pend3", pending_cnt, 3);
        tick(); m1_read = 1'b0;
        @(negedge clk); chk("t3_pend4", pending_cnt, 4);

        // write passes a full FIFO
        tick(); m1_write = 1'b1; m1_address = 32'h200;
        m1_writedata = 32'h12345678; m1_byteenable = 4'hF;
        @(negedge clk);
        chk("t4_swrite", s_write, 1);
        chk("t4_wait", m1_waitrequest, 0);
        chk("t4_addr", s_address, 32'h200);
        chk("t4_wdata", s_writedata, 32'h12345678);
        tick(); m1_write = 1'b0;
        @(negedge clk); chk("t4_pend", pending_cnt, 4);
        tick(); s_readdatavalid = 1'b1;
        repeat (4) tick();
        s_readdatavalid = 1'b0;

        // stalled contention: m0 holds grant until accepted
        s_waitrequest = 1'b1;
        m0_read = 1'b1; m0_address = 32'hA0;
        m1_read = 1'b1; m1_address = 32'hB0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_addr", s_address, 32'hA0);
            chk("t5_sread", s_read, 1);
            chk("t5_w0", m0_waitrequest, 1);
            tick();
        end
        s_waitrequest = 1'b0;
        @(negedge clk);
        chk("t5_acc0", s_address, 32'hA0);
        chk("t5_w0lo", m0_waitrequest, 0);
        tick();
        @(negedge clk);
        chk("t5_acc1", s_address, 32'hB0);
        chk("t5_w1lo", m1_waitrequest, 0);
        tick(); m0_read = 1'b0; m1_read = 1'b0; s_readdatavalid = 1'b1;
        tick(); tick(); s_readdatavalid = 1'b0;
        @(negedge clk); chk("t5_pend0", pending_cnt, 0);

        // reset with two reads outstanding
        tick(); m0_read = 1'b1; m0_address = 32'h10;
        tick(); tick(); m0_read = 1'b0;
        @(negedge clk); chk("t6_pend2", pending_cnt, 2);
        tick(); rest = 1'b1;
        @(negedge clk);
        chk("t6_rst_w0", m0_waitrequest, 1);
        chk("t6_rst_pend", pending_cnt, 2);
        tick(); rest = 1'b0; s_readdatavalid = 1'b1;
        @(negedge clk);
        chk("t6_rdv0a", m0_readdatavalid, 0);
        chk("t6_pend0", pending_cnt, 0);
        tick();
        @(negedge clk);
        chk("t6_rdv0b", m0_readdatavalid, 0);
        chk("t6_rdv1b", m1_readdatavalid, 0);
        chk("t6_err", err_unexp_rdv, 1);
        tick(); s_readdatavalid = 1'b0;
        @(negedge clk);
        chk("t6_sticky", err_unexp_rdv, 1);
        chk("t6_pend", pending_cnt, 0);

        tick(); rest = 1'b1;
        tick(); rest = 1'b0;

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            rest = ($urandom_range(0, 199) == 0);
            m0_read = ($urandom_range(0, 99) < 50);
            m0_write = ($urandom_range(0, 99) < 15);
            m1_read = ($urandom_range(0, 99) < 50);
            m1_write = ($urandom_range(0, 99) < 25);
            m0_address = $urandom; m1_address = $urandom;
            m0_writedata = $urandom; m1_writedata = $urandom;
            m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
            s_waitrequest = ($urandom_range(0, 99) < 25);
            s_readdata = $urandom;
            if (q.size() > 0) s_readdatavalid = ($urandom_range(0, 99) < 55);
            else s_readdatavalid = ($urandom_range(0, 99) < 2);
            tick();
        end
        rest = 1'b0; m0_read = 1'b0; m0_write = 1'b0;
        m1_read = 1'b0; m1_write = 1'b0; s_readdatavalid = 1'b0;
        tick();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
